fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction fetch stage that sits directly upstream of the instruction ROM port.
- Owns the fetch PC and drives the ROM address.
- Captures the returned instruction words into a small in-order FIFO and presents them to decode with a valid/ready handshake.
- Handles branch/jump redirects by flushing queued words and restarting fetch at the new PC.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset; bits [1:0] must be 0.
- DEPTH, 4, instruction FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- romAddr  out  32  fetch address to ROM port A; always equals fetchPc.
- romData  in  32  instruction word returned by ROM.
- romAddrOut  in  32  address echoed by ROM with romData.
- romReadValid  in  1  romData/romAddrOut are valid this cycle.
- romReady  in  1  ROM is able to service requests.
- redirectValid  in  1  one-cycle request to restart fetch.
- redirectPc  in  32  new fetch PC; bits [1:0] are ignored (forced 0).
- instValid  out  1  FIFO head is valid.
- instData  out  32  FIFO head instruction word.
- instPc  out  32  PC of the FIFO head.
- instReady  in  1  decode accepts the head this cycle.
- queueCount  out  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset (async assert, sync-safe deassert on the next clk edge):
  - fetchPc = RESET_PC, FIFO empty, queueCount = 0.
  - instValid = 0; instData = 0; instPc = 0.
  - romAddr = RESET_PC.
- State: fetchPc[31:0], FIFO storage {pc, word} x DEPTH, rdPtr, wrPtr, count.
- romAddr = fetchPc, combinationally, every cycle, including while the FIFO is full.
- pop = instValid && instReady.
- hit = romReady && romReadValid && (romAddrOut[31:2] == fetchPc[31:2]).
  - A response whose echoed address mismatches fetchPc is stale and is discarded silently.
- push = hit && !redirectValid && (count < DEPTH || pop).
  - A push writes {fetchPc, romData} at wrPtr and sets fetchPc <= fetchPc + 4.
  - fetchPc wraps modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
- Full with a simultaneous pop: push is allowed; count is unchanged.
- Full without a pop: no push, fetchPc holds, and the ROM keeps being presented the same address.
- Empty with a simultaneous push: the word is not visible until the next cycle (no bypass). Minimum latency from a ROM hit to instValid is 1 cycle.
- Steady state with a combinational ROM and instReady held high: one instruction per cycle after the initial 1-cycle fill.
- Redirect (redirectValid = 1) has priority over push and pop:
  - FIFO is flushed: count = 0, rdPtr = wrPtr = 0.
  - fetchPc <= {redirectPc[31:2], 2'b00}.
  - Any ROM response and any pop in that cycle are ignored; decode must treat the head as killed.
  - instValid = 0 in the following cycle.
- Back-to-back redirects: the last one wins; no words are pushed between them.
- Redirect to the current fetchPc still flushes.
- instValid = (count != 0). instData and instPc come from the head entry, registered storage, with no combinational path from romData.
- Head stability: while instValid && !instReady, instData, instPc and instValid hold stable until a pop or a redirect.
- romReady = 0: no push, fetchPc holds, FIFO drains normally.
- queueCount reflects the registered count, never exceeds DEPTH, and pointers wrap modulo DEPTH.

Test Plan:
- Reset then stream: connect the 32-bit combinational ROM model (0x0 = 32'h37010080, 0x4 = 32'h93001000, 0x8 = 32'h93002000), instReady = 1 -> after 1 cycle instPc/instData = 0/37010080, then 4/93001000, then 8/93002000 on consecutive cycles; romAddr steps 0, 4, 8, C.
- Backpressure: instReady = 0 for 10 cycles -> queueCount reaches 4 and holds, romAddr stays at 32'h10, head stays 0/37010080. On release, PCs 0, 4, 8, C, 10 emerge in order with no gaps and no duplicates.
- Redirect with full queue: redirectValid = 1 with redirectPc = 32'h0000_0033 -> next cycle instValid = 0 and queueCount = 0, romAddr = 32'h30; then head = 30/9300c000.
- Stale response: ROM model echoes romAddrOut = 32'h8 while fetchPc = 32'h30 -> no push, queueCount unchanged, fetchPc stays 32'h30.
- Simultaneous full push+pop: FIFO full, hit and instReady = 1 in the same cycle -> queueCount stays 4, head advances by one PC, tail receives the new word.
- Async reset mid-stream: drop rst_n between clock edges with queueCount = 3 -> instValid = 0 and romAddr = RESET_PC immediately (before the next edge). After release, fetch restarts cleanly at 0/37010080.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, drives the ROM address and
// queues the returned words in an in-order FIFO. Decode reads the FIFO through
// a valid/ready handshake. A redirect flushes the FIFO and restarts fetch at the
// new PC.
module fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic [31:0]            romAddr,
  input  logic [31:0]            romData,
  input  logic [31:0]            romAddrOut,
  input  logic                   romReadValid,
  input  logic                   romReady,
  input  logic                   redirectValid,
  input  logic [31:0]            redirectPc,
  output logic                   instValid,
  output logic [31:0]            instData,
  output logic [31:0]            instPc,
  input  logic                   instReady,
  output logic [$clog2(DEPTH):0] queueCount
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);

  logic [31:0]     r_fetch_pc;
  logic [31:0]     r_pc_mem   [DEPTH];
  logic [31:0]     r_word_mem [DEPTH];
  logic [PtrW-1:0] r_rd_ptr;
  logic [PtrW-1:0] r_wr_ptr;
  logic [CntW-1:0] r_count;

  logic w_pop;
  logic w_hit;
  logic w_push;
  logic w_unused;

  // Low address bits carry no information: fetch is always word aligned.
  assign w_unused = ^{romAddrOut[1:0], redirectPc[1:0]};

  // A response only counts if it echoes the address currently being fetched;
  // anything else is a leftover from before a redirect and is dropped.
  assign w_pop  = instValid && instReady;
  assign w_hit  = romReady && romReadValid && (romAddrOut[31:2] == r_fetch_pc[31:2]);
  assign w_push = w_hit && !redirectValid && ((r_count != FullCnt) || w_pop);

  // Outputs come straight from registered state; no bypass from romData.
  assign romAddr    = r_fetch_pc;
  assign instValid  = (r_count != '0);
  assign instData   = r_word_mem[r_rd_ptr];
  assign instPc     = r_pc_mem[r_rd_ptr];
  assign queueCount = r_count;

  // FIFO storage: write {pc, word} at the tail on every accepted response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pc_mem[i]   <= '0;
        r_word_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_pc_mem[r_wr_ptr]   <= r_fetch_pc;
      r_word_mem[r_wr_ptr] <= romData;
    end
  end

  // Fetch PC, pointers and occupancy; a redirect overrides push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else if (redirectValid) begin
      r_fetch_pc <= {redirectPc[31:2], 2'b00};
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr   <= r_wr_ptr + PtrOne;
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrOne;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntOne;
        2'b01:   r_count <= r_count - CntOne;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: combinational ROM model, a queue-based reference model
// checked every cycle, and directed scenarios with literal expectations.
module tb_fetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic [31:0] romAddr;
  logic [31:0] romData;
  logic [31:0] romAddrOut;
  logic        romReadValid;
  logic        romReady;
  logic        redirectValid;
  logic [31:0] redirectPc;
  logic        instValid;
  logic [31:0] instData;
  logic [31:0] instPc;
  logic        instReady;
  logic [2:0]  queueCount;

  logic        stale_en;
  logic [31:0] stale_addr;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_queue #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .romAddr       (romAddr),
    .romData       (romData),
    .romAddrOut    (romAddrOut),
    .romReadValid  (romReadValid),
    .romReady      (romReady),
    .redirectValid (redirectValid),
    .redirectPc    (redirectPc),
    .instValid     (instValid),
    .instData      (instData),
    .instPc        (instPc),
    .instReady     (instReady),
    .queueCount    (queueCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h3701_0080;
      32'h0000_0004: return 32'h9300_1000;
      32'h0000_0008: return 32'h9300_2000;
      32'h0000_0030: return 32'h9300_c000;
      default:       return 32'hA500_0000 ^ a;
    endcase
  endfunction

  // Combinational ROM; the echo can be forced to a stale address.
  assign romData    = rom_word(romAddr);
  assign romAddrOut = stale_en ? stale_addr : romAddr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of {pc, word} plus the fetch PC.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc = RESET_PC;

  initial begin : model
    bit          do_pop;
    bit          do_push;
    logic [31:0] echo;
    ent_t        e;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        m_pc = RESET_PC;
      end else if (redirectValid) begin
        mq.delete();
        m_pc = {redirectPc[31:2], 2'b00};
      end else begin
        echo    = stale_en ? stale_addr : m_pc;
        do_pop  = (mq.size() != 0) && instReady;
        do_push = romReady && romReadValid && (echo[31:2] == m_pc[31:2])
                  && ((mq.size() < DEPTH) || do_pop);
        if (do_pop) mq.delete(0);
        if (do_push) begin
          e.pc   = m_pc;
          e.word = rom_word(m_pc);
          mq.push_back(e);
          m_pc = m_pc + 32'd4;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin : compare
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        chk("cmp_valid", 32'(instValid), 32'(mq.size() != 0));
        chk("cmp_count", 32'(queueCount), 32'(mq.size()));
        chk("cmp_romaddr", romAddr, m_pc);
        if (mq.size() != 0) begin
          chk("cmp_pc", instPc, mq[0].pc);
          chk("cmp_data", instData, mq[0].word);
        end
      end
    end
  end

  initial begin : stim
    rst_n         = 1'b0;
    romReadValid  = 1'b1;
    romReady      = 1'b1;
    instReady     = 1'b1;
    redirectValid = 1'b0;
    redirectPc    = '0;
    stale_en      = 1'b0;
    stale_addr    = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(instValid), 32'd0);
    chk("rst_data", instData, 32'd0);
    chk("rst_pc", instPc, 32'd0);
    chk("rst_romaddr", romAddr, 32'd0);
    chk("rst_count", 32'(queueCount), 32'd0);
    rst_n = 1'b1;

    // Stream from reset.
    @(negedge clk);
    chk("s0_valid", 32'(instValid), 32'd1);
    chk("s0_pc", instPc, 32'h0);
    chk("s0_data", instData, 32'h3701_0080);
    chk("s0_romaddr", romAddr, 32'h4);
    @(negedge clk);
    chk("s1_pc", instPc, 32'h4);
    chk("s1_data", instData, 32'h9300_1000);
    chk("s1_romaddr", romAddr, 32'h8);
    @(negedge clk);
    chk("s2_pc", instPc, 32'h8);
    chk("s2_data", instData, 32'h9300_2000);
    chk("s2_romaddr", romAddr, 32'hC);

    // Restart at 0 with decode stalled for 10 cycles.
    instReady     = 1'b0;
    redirectValid = 1'b1;
    redirectPc    = 32'h0;
    @(negedge clk);
    redirectValid = 1'b0;
    chk("bp_flush_valid", 32'(instValid), 32'd0);
    chk("bp_flush_romaddr", romAddr, 32'h0);
    repeat (9) @(negedge clk);
    chk("bp_count", 32'(queueCount), 32'd4);
    chk("bp_romaddr", romAddr, 32'h10);
    chk("bp_head_pc", instPc, 32'h0);
    chk("bp_head_data", instData, 32'h3701_0080);

    // Release: full queue pops and pushes in the same cycle.
    instReady = 1'b1;
    @(negedge clk);
    chk("fpp_count", 32'(queueCount), 32'd4);
    chk("fpp_head_pc", instPc, 32'h4);
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      chk("drain_pc", instPc, 32'(4 * k));
    end

    // Redirect while full; then hold a stale echo.
    redirectValid = 1'b1;
    redirectPc    = 32'h0000_0033;
    @(negedge clk);
    redirectValid = 1'b0;
    instReady     = 1'b0;
    stale_en      = 1'b1;
    stale_addr    = 32'h8;
    chk("rd_valid", 32'(instValid), 32'd0);
    chk("rd_count", 32'(queueCount), 32'd0);
    chk("rd_romaddr", romAddr, 32'h30);
    repeat (2) @(negedge clk);
    chk("stale_count", 32'(queueCount), 32'd0);
    chk("stale_romaddr", romAddr, 32'h30);
    stale_en = 1'b0;
    @(negedge clk);
    chk("rd_head_pc", instPc, 32'h30);
    chk("rd_head_data", instData, 32'h9300_c000);
    repeat (2) @(negedge clk);
    chk("pre_rst_count", 32'(queueCount), 32'd3);

    // Asynchronous reset between edges.
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(instValid), 32'd0);
    chk("arst_romaddr", romAddr, RESET_PC);
    chk("arst_count", 32'(queueCount), 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    instReady = 1'b1;
    @(negedge clk);
    chk("arst_restart_pc", instPc, 32'h0);
    chk("arst_restart_data", instData, 32'h3701_0080);

    // ROM not ready: queue drains, PC holds.
    romReady = 1'b0;
    @(negedge clk);
    chk("nrdy_count", 32'(queueCount), 32'd0);
    chk("nrdy_romaddr", romAddr, 32'h4);
    romReady = 1'b1;

    // Back-to-back redirects: the last one wins.
    redirectValid = 1'b1;
    redirectPc    = 32'h100;
    @(negedge clk);
    redirectPc = 32'h8;
    @(negedge clk);
    redirectValid = 1'b0;
    chk("b2b_count", 32'(queueCount), 32'd0);
    chk("b2b_romaddr", romAddr, 32'h8);
    @(negedge clk);
    chk("b2b_head_pc", instPc, 32'h8);
    chk("b2b_head_data", instData, 32'h9300_2000);

    // PC wraps past the top of the address space.
    redirectValid = 1'b1;
    redirectPc    = 32'hFFFF_FFFF;
    @(negedge clk);
    redirectValid = 1'b0;
    chk("wrap_romaddr0", romAddr, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("wrap_head_pc", instPc, 32'hFFFF_FFFC);
    chk("wrap_romaddr1", romAddr, 32'h0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
